ram_access_ctrl: RTL and testbench

//  Initiator-side controller for the 128-word register-file RAM. It accepts read/write burst

---
 rtl/ram_access_ctrl_if.sv | 41 ++++
 rtl/ram_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_if.sv
// Core-side request/write-data/response bundle of the RAM access controller.
// master = load/store path (requester), slave = ram_access_ctrl.
interface ram_access_ctrl_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 3
) ();
    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    // Write-data channel
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [WORD_WIDTH-1:0] wdata;

    // Read-response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WORD_WIDTH-1:0] resp_data;
    logic                  resp_last;

    modport master (
        output req_valid, req_we, req_addr, req_len,
        output wdata_valid, wdata,
        output resp_ready,
        input  req_ready, wdata_ready,
        input  resp_valid, resp_data, resp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        input  wdata_valid, wdata,
        input  resp_ready,
        output req_ready, wdata_ready,
        output resp_valid, resp_data, resp_last
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for the 128-word register-file RAM.
// Accepts read/write bursts over a valid/ready handshake, drives the RAM pins and
// captures the RAM's combinational read data into a one-entry response register.
module ram_access_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_data_in_o,
    output logic                  ram_rd_en_o,
    output logic                  ram_wr_en_o,
    input  logic [WORD_WIDTH-1:0] ram_data_out_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,   cur_addr_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_last_q,  resp_last_d;
    logic [WORD_WIDTH-1:0] resp_data_q,  resp_data_d;

    // Ungated strobes from the FSM; the outputs AND these with rst_n so the RAM and
    // the requester see nothing active while reset is asserted.
    logic                  in_idle;
    logic                  in_wr;
    logic                  issue;
    logic                  wr_fire;
    logic                  rd_en_gated;
    logic                  wr_en_gated;

    assign in_idle = (state_q == ST_IDLE);
    assign in_wr   = (state_q == ST_WR);
    // A read beat is issued only when the response register is free or being drained
    // on this same edge, so a stalled consumer never loses a beat.
    assign issue   = (state_q == ST_RD) && (!resp_valid_q || bus.resp_ready);
    assign wr_fire = in_wr && bus.wdata_valid;

    assign rd_en_gated = rst_n & issue;
    assign wr_en_gated = rst_n & wr_fire;

    // State and datapath registers, cleared asynchronously; a burst in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Next-state logic: burst sequencing plus the response-register load/drain.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        resp_last_d  = resp_last_q;
        resp_data_d  = resp_data_q;
        // The held beat drains on a consumer handshake; an issue below may reload it.
        resp_valid_d = resp_valid_q && !bus.resp_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cur_addr_d   = bus.req_addr;
                    beats_left_d = bus.req_len;
                    state_d      = bus.req_we ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                if (wr_fire) begin
                    // Address wraps naturally at 2^ADDR_WIDTH.
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    if (beats_left_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - LEN_WIDTH'(1);
                    end
                end
            end

            ST_RD: begin
                if (issue) begin
                    resp_data_d  = ram_data_out_i;
                    resp_valid_d = 1'b1;
                    resp_last_d  = (beats_left_q == '0);
                    cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
                    if (beats_left_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - LEN_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake readies are only offered in their own state and never during reset.
    assign bus.req_ready   = rst_n & in_idle;
    assign bus.wdata_ready = rst_n & in_wr;

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_last   = resp_last_q;
    assign bus.resp_data   = resp_data_q;

    assign ram_addr_o  = cur_addr_q;
    assign ram_rd_en_o = rd_en_gated;
    assign ram_wr_en_o = wr_en_gated;

    // Data bus to the RAM is forced to zero whenever no write strobe is present.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_WIDTH; gi++) begin : g_din_gate
            assign ram_data_in_o[gi] = bus.wdata[gi] & wr_en_gated;
        end
    endgenerate

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a behavioural RAM, a shadow memory holding
// the expected contents, and a monitor that checks RAM writes and read responses.
module tb_ram_access_ctrl;
    localparam int WW = 32;
    localparam int AW = 7;
    localparam int LW = 3;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_data_in;
    logic [WW-1:0] ram_data_out;
    logic          ram_rd_en;
    logic          ram_wr_en;

    ram_access_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ram_addr_o    (ram_addr),
        .ram_data_in_o (ram_data_in),
        .ram_rd_en_o   (ram_rd_en),
        .ram_wr_en_o   (ram_wr_en),
        .ram_data_out_i(ram_data_out)
    );

    // Behavioural RAM: synchronous write, combinational read, bus idle when not enabled.
    logic [WW-1:0] ram_mem [DEPTH];
    always @(posedge clk) if (ram_wr_en) ram_mem[ram_addr] <= ram_data_in;
    assign ram_data_out = ram_rd_en ? ram_mem[ram_addr] : '0;

    // Reference state
    logic [WW-1:0] shadow [DEPTH];
    bit            known  [DEPTH];

    typedef struct packed { logic [WW-1:0] data; logic last; logic known; } rd_exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [WW-1:0] data; } wr_exp_t;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    int total = 0;
    int bad = 0;
    int wr_pulses = 0;
    int rr_mode = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    endtask

    // Consumer ready pattern
    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: bus.resp_ready = 1'b1;
                1: bus.resp_ready = ~bus.resp_ready;
                2: bus.resp_ready = ($urandom_range(0, 3) != 0);
                default: bus.resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        rd_exp_t e;
        wr_exp_t w;
        if (rst_n) begin
            if (ram_rd_en && ram_wr_en) fail("rd_wr_both", 1, 0);
            if (!ram_wr_en && ram_data_in != '0) fail("din_not_zero", ram_data_in, 0);
            if (bus.req_ready && (ram_rd_en || ram_wr_en || bus.wdata_ready))
                fail("idle_activity", {ram_rd_en, ram_wr_en, bus.wdata_ready}, 0);
            if (bus.resp_valid && !bus.resp_ready) chk("rd_en_stall", ram_rd_en, 0);
            if (ram_wr_en) begin
                wr_pulses++;
                if (wr_q.size() == 0) fail("wr_unexpected", ram_addr, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", ram_addr, w.addr);
                    chk("wr_data", ram_data_in, w.data);
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (rd_q.size() == 0) fail("resp_unexpected", bus.resp_data, 0);
                else begin
                    e = rd_q.pop_front();
                    if (e.known) chk("resp_data", bus.resp_data, e.data);
                    chk("resp_last", bus.resp_last, e.last);
                end
            end
        end
    end

    task automatic issue_req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int n = 0;
        logic [AW-1:0] a;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_len   = len;
        while (!bus.req_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 1000) fail("req_timeout", 0, 1);
        if (!we) begin
            for (int k = 0; k <= int'(len); k++) begin
                a = addr + AW'(k);
                rd_q.push_back('{data: shadow[a], last: (k == int'(len)), known: known[a]});
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input logic [WW-1:0] d [8], input int gap [8]);
        int n;
        logic [AW-1:0] a;
        $display("txn write addr=%0d len=%0d", addr, len);
        issue_req(1'b1, addr, len);
        for (int k = 0; k <= int'(len); k++) begin
            bus.wdata_valid = 1'b0;
            repeat (gap[k]) begin @(posedge clk); #1; end
            a = addr + AW'(k);
            bus.wdata_valid = 1'b1;
            bus.wdata = d[k];
            wr_q.push_back('{addr: a, data: d[k]});
            shadow[a] = d[k];
            known[a]  = 1'b1;
            n = 0;
            while (!bus.wdata_ready && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) fail("wdata_timeout", 0, 1);
            @(posedge clk); #1;
            bus.wdata_valid = 1'b0;
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        $display("txn read  addr=%0d len=%0d", addr, len);
        issue_req(1'b0, addr, len);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rd_q.size() != 0 || !bus.req_ready) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 1000) fail("drain_timeout", rd_q.size(), 0);
    endtask

    logic [WW-1:0] d [8];
    int            g [8];

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 0; bus.wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin shadow[i] = '0; known[i] = 1'b0; end
        for (int i = 0; i < 8; i++) begin d[i] = '0; g[i] = 0; end

        // Reset values
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_last", bus.resp_last, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_req_ready", bus.req_ready, 1);

        // Single write then single read at address 5, with latency check
        rr_mode = 0;
        d[0] = 32'hDEADBEEF;
        write_burst(7'd5, 3'd0, d, g);
        read_burst(7'd5, 3'd0);
        @(posedge clk); #1;
        chk("lat_resp_valid", bus.resp_valid, 1);
        chk("lat_resp_data", bus.resp_data, 32'hDEADBEEF);
        chk("lat_resp_last", bus.resp_last, 1);
        wait_drain();

        // Wrapping write burst 126..1 and read-back
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
        write_burst(7'd126, 3'd3, d, g);
        @(posedge clk); #1;
        chk("wrap_mem126", ram_mem[126], 32'h11);
        chk("wrap_mem127", ram_mem[127], 32'h22);
        chk("wrap_mem0", ram_mem[0], 32'h33);
        chk("wrap_mem1", ram_mem[1], 32'h44);
        read_burst(7'd126, 3'd3);
        wait_drain();

        // Len-7 read with toggling resp_ready
        for (int i = 0; i < 8; i++) d[i] = $urandom;
        write_burst(7'd40, 3'd7, d, g);
        rr_mode = 1;
        read_burst(7'd40, 3'd7);
        wait_drain();
        rr_mode = 0;

        // Write burst with wdata_valid pattern 1,0,0,1,1
        wr_pulses = 0;
        d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
        g[1] = 2;
        write_burst(7'd60, 3'd2, d, g);
        g[1] = 0;
        chk("gap_req_ready_back", bus.req_ready, 1);
        chk("gap_wr_pulses", wr_pulses, 3);

        // Reset in the middle of a read burst
        read_burst(7'd40, 3'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rd_en_before", ram_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", ram_rd_en, 0);
        chk("mid_rst_wr_en", ram_wr_en, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        rd_q.delete();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_ready", bus.req_ready, 1);
        read_burst(7'd126, 3'd3);
        wait_drain();

        // Random traffic
        rr_mode = 2;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) begin
                    d[i] = $urandom;
                    g[i] = $urandom_range(0, 2);
                end
                write_burst(AW'($urandom), LW'($urandom), d, g);
            end else begin
                read_burst(AW'($urandom), LW'($urandom));
                if ($urandom_range(0, 1) == 1) wait_drain();
            end
        end
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_wr_q_empty", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
